avalon_timer_bank: RTL and testbench
====================================

# avalon_timer_bank

Parametrised bank of NUM_TIMERS independent down-counting timers behind a single Avalon-MM slave port, one level-sensitive interrupt per channel plus an aggregate. Each channel has a programmable prescaler, reload value, one-shot/periodic mode and write-1-to-clear status. The block sits on the peripheral bus next to the other memory-mapped peripherals.

## Interface
- NUM_TIMERS, 4: channel count, 1..16.
- WIDTH, 32: counter/reload/compare width, 8..32.
- PRESCALE_W, 8: prescaler width, 1..16.
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- read_n  in  1  Avalon read strobe, active-low.
- write_n  in  1  Avalon write strobe, active-low.
- address  in  32  byte address. [5:2] is the register index. [9:6] is the channel index.
- writeData  in  32  write data.
- readData  out  32  registered read data.
- irq  out  NUM_TIMERS  per-channel interrupt.
- irq_any  out  1  OR of irq.
- pwm_out  out  NUM_TIMERS  PWM outputs. Present only with TIMER_PWM_EN.

## Operation
- Per-channel registers, by index:
  - 0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IE.
  - 1 PRESCALE: PRESCALE_W bits.
  - 2 RELOAD.
  - 3 COUNT: read/write.
  - 4 COMPARE.
  - 5 STATUS: bit0 EXPIRED, write 1 to clear.
- Indices 6..15 and channels ≥ NUM_TIMERS: reads return 0, writes are ignored.
- Write data is truncated to the field width. Reads zero-extend to 32 bits.
- Prescaler: counts 0..PRESCALE while EN=1. tick is asserted when prescaler == PRESCALE, and the prescaler then wraps to 0.
- On tick with COUNT≠0: COUNT decrements by 1.
- On tick with COUNT==0:
  - EXPIRED is set.
  - PERIODIC=1: COUNT reloads from RELOAD.
  - PERIODIC=0: EN clears and COUNT stays 0.
- Period = (RELOAD+1)·(PRESCALE+1) clocks. RELOAD=0 in periodic mode expires on every tick.
- A CTRL write that takes EN from 0 to 1 loads COUNT from RELOAD and clears the prescaler. Writing EN=1 while already enabled changes only the mode bits.
- EN=0 freezes COUNT and the prescaler.
- irq[i] = EXPIRED & IE, level-sensitive, held until EXPIRED is cleared.
- Simultaneous events:
  - Hardware EXPIRED set and W1C clear in the same cycle: the set wins.
  - COUNT write and tick in the same cycle: the write wins.
  - CTRL write clearing EN on a tick: no decrement.
  - read_n and write_n both low: the write is performed and the read returns the pre-write value.

## Timing
- Reset values: readData, irq, irq_any, pwm_out and every register are 0.
- Read latency is 1. The read is sampled at edge N and readData is valid after edge N. readData is 0 in cycles following no read.
- No waitrequest. Writes take effect at the sampling edge.
- Enable written at edge E with PRESCALE=0, RELOAD=R: COUNT reaches 0 after edge E+R, and EXPIRED/irq rise after edge E+R+1.
- irq_any is registered, in the same cycle as irq.
- Asserting rst_n low mid-count clears everything immediately. Counting restarts only when software enables the channel again.

## Configuration
- TIMER_PWM_EN defined:
  - COMPARE register and pwm_out port exist.
  - pwm_out[i] is registered and equals EN & (COUNT < COMPARE).
  - COMPARE=0 gives a constant low output. COMPARE > RELOAD gives a constant high output while enabled.
- TIMER_PWM_EN undefined:
  - No pwm_out port.
  - Index 4 reads 0 and ignores writes.

## Structure
- Package avalon_timer_pkg holds:
  - register index localparams (REG_CTRL..REG_STATUS);
  - CTRL and STATUS bit positions;
  - packed struct typedef timer_ctrl_t.
- Sub-module timer_channel, instantiated NUM_TIMERS times via generate. It holds the prescaler, counter, registers, status and PWM.
- The top level holds address decode, per-channel write strobes, the read mux and the readData register.

## Test plan
- Reset, then read CTRL/COUNT/STATUS of every channel -> all 0; irq=0.
- Ch0: PRESCALE=0, RELOAD=4, CTRL=0b111 written at edge E -> irq[0] rises after E+5 and irq_any=1. Write STATUS=1 -> irq[0] low one cycle later. Next expiry follows 5 clocks after the previous one.
- Ch2: one-shot, RELOAD=3, PRESCALE=2 -> EXPIRED after 12 clocks; CTRL reads EN=0; COUNT stays 0.
- W1C on STATUS in the same cycle as an expiry -> EXPIRED stays 1.
- Read channel index NUM_TIMERS and register index 9 -> 0. Simultaneous read/write of COUNT=0x55 -> returns the old value, and a later read returns 0x55.
- With TIMER_PWM_EN: RELOAD=9, COMPARE=3, PRESCALE=0 -> pwm_out high 3 of every 10 clocks.

Source files
------------

// File: rtl/avalon_timer_pkg.sv
// Shared register map, control/status bit positions and the control-word
// type for the Avalon-MM timer bank.
package avalon_timer_pkg;

   localparam logic [3:0] REG_CTRL     = 4'd0;
   localparam logic [3:0] REG_PRESCALE = 4'd1;
   localparam logic [3:0] REG_RELOAD   = 4'd2;
   localparam logic [3:0] REG_COUNT    = 4'd3;
   localparam logic [3:0] REG_COMPARE  = 4'd4;
   localparam logic [3:0] REG_STATUS   = 4'd5;

   localparam int CTRL_EN_BIT        = 0;
   localparam int CTRL_PERIODIC_BIT  = 1;
   localparam int CTRL_IE_BIT        = 2;
   localparam int STATUS_EXPIRED_BIT = 0;

   typedef struct packed {
      logic ie;
      logic periodic;
      logic en;
   } timer_ctrl_t;

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: prescaler, counter, control/status registers,
// interrupt and (with TIMER_PWM_EN) a compare register driving a PWM output.
module timer_channel
   import avalon_timer_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int PRESCALE_W = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en_i,
   input  logic [3:0]  reg_idx_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        irq_o,
   output logic        irq_d_o
`ifdef TIMER_PWM_EN
   ,output logic       pwm_o
`endif
);

   timer_ctrl_t           ctrl_q, ctrl_d;
   timer_ctrl_t           wctrl_s;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic [WIDTH-1:0]      reload_q, reload_d;
   logic [WIDTH-1:0]      count_q, count_d;
   logic                  expired_q, expired_d;
   logic                  irq_q, irq_d;
   logic                  wr_ctrl_s, wr_prescale_s, wr_reload_s, wr_count_s, wr_status_s;
   logic                  en_rise_s, run_s, tick_s, expire_s;
`ifdef TIMER_PWM_EN
   logic [WIDTH-1:0]      compare_q, compare_d;
   logic                  wr_compare_s;
   logic                  pwm_q, pwm_d;
`endif

   // Write strobes and decoded control word
   always_comb begin
      wr_ctrl_s     = wr_en_i && (reg_idx_i == REG_CTRL);
      wr_prescale_s = wr_en_i && (reg_idx_i == REG_PRESCALE);
      wr_reload_s   = wr_en_i && (reg_idx_i == REG_RELOAD);
      wr_count_s    = wr_en_i && (reg_idx_i == REG_COUNT);
      wr_status_s   = wr_en_i && (reg_idx_i == REG_STATUS);
`ifdef TIMER_PWM_EN
      wr_compare_s  = wr_en_i && (reg_idx_i == REG_COMPARE);
`endif
      wctrl_s.en       = wdata_i[CTRL_EN_BIT];
      wctrl_s.periodic = wdata_i[CTRL_PERIODIC_BIT];
      wctrl_s.ie       = wdata_i[CTRL_IE_BIT];
      en_rise_s = wr_ctrl_s && wctrl_s.en && !ctrl_q.en;
      // A CTRL write that disables the channel freezes it in the same cycle.
      run_s    = ctrl_q.en && !(wr_ctrl_s && !wctrl_s.en);
      tick_s   = run_s && (presc_q >= prescale_q);
      expire_s = tick_s && (count_q == {WIDTH{1'b0}});
   end

   // Next-state: hardware counting first, software writes override
   always_comb begin
      ctrl_d     = ctrl_q;
      prescale_d = prescale_q;
      presc_d    = presc_q;
      reload_d   = reload_q;
      count_d    = count_q;
`ifdef TIMER_PWM_EN
      compare_d  = compare_q;
`endif
      if (run_s) begin
         presc_d = tick_s ? {PRESCALE_W{1'b0}} : presc_q + PRESCALE_W'(1);
      end else begin
         presc_d = presc_q;
      end
      if (expire_s) begin
         if (ctrl_q.periodic) begin
            count_d = reload_q;
         end else begin
            ctrl_d.en = 1'b0;
         end
      end else if (tick_s) begin
         count_d = count_q - WIDTH'(1);
      end else begin
         count_d = count_q;
      end
      if (wr_ctrl_s) begin
         ctrl_d = wctrl_s;
         if (en_rise_s) begin
            count_d = reload_q;
            presc_d = {PRESCALE_W{1'b0}};
         end else begin
            presc_d = presc_d;
         end
      end else begin
         ctrl_d = ctrl_d;
      end
      if (wr_prescale_s) begin
         prescale_d = wdata_i[PRESCALE_W-1:0];
      end else begin
         prescale_d = prescale_q;
      end
      if (wr_reload_s) begin
         reload_d = wdata_i[WIDTH-1:0];
      end else begin
         reload_d = reload_q;
      end
      if (wr_count_s) begin
         count_d = wdata_i[WIDTH-1:0];
      end else begin
         count_d = count_d;
      end
`ifdef TIMER_PWM_EN
      if (wr_compare_s) begin
         compare_d = wdata_i[WIDTH-1:0];
      end else begin
         compare_d = compare_q;
      end
      pwm_d = ctrl_d.en && (count_d < compare_d);
`endif
      // Hardware set takes priority over a write-1-to-clear in the same cycle.
      expired_d = (expired_q && !(wr_status_s && wdata_i[STATUS_EXPIRED_BIT])) || expire_s;
      irq_d     = expired_d && ctrl_d.ie;
   end

   // Channel state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q     <= '{ie: 1'b0, periodic: 1'b0, en: 1'b0};
         prescale_q <= {PRESCALE_W{1'b0}};
         presc_q    <= {PRESCALE_W{1'b0}};
         reload_q   <= {WIDTH{1'b0}};
         count_q    <= {WIDTH{1'b0}};
         expired_q  <= 1'b0;
         irq_q      <= 1'b0;
`ifdef TIMER_PWM_EN
         compare_q  <= {WIDTH{1'b0}};
         pwm_q      <= 1'b0;
`endif
      end else begin
         ctrl_q     <= ctrl_d;
         prescale_q <= prescale_d;
         presc_q    <= presc_d;
         reload_q   <= reload_d;
         count_q    <= count_d;
         expired_q  <= expired_d;
         irq_q      <= irq_d;
`ifdef TIMER_PWM_EN
         compare_q  <= compare_d;
         pwm_q      <= pwm_d;
`endif
      end
   end

   // Register read view, zero-extended to the bus width
   always_comb begin
      case (reg_idx_i)
         REG_CTRL:     rdata_o = {29'd0, ctrl_q};
         REG_PRESCALE: rdata_o = 32'(prescale_q);
         REG_RELOAD:   rdata_o = 32'(reload_q);
         REG_COUNT:    rdata_o = 32'(count_q);
`ifdef TIMER_PWM_EN
         REG_COMPARE:  rdata_o = 32'(compare_q);
`endif
         REG_STATUS:   rdata_o = {31'd0, expired_q};
         default:      rdata_o = 32'd0;
      endcase
   end

   assign irq_o   = irq_q;
   assign irq_d_o = irq_d;
`ifdef TIMER_PWM_EN
   assign pwm_o   = pwm_q;
`endif

endmodule

// File: rtl/avalon_timer_bank.sv
// Avalon-MM bank of NUM_TIMERS timer channels: address decode, read mux,
// registered read data and aggregate interrupt. TIMER_PWM_EN adds COMPARE and pwm_out.
module avalon_timer_bank
   import avalon_timer_pkg::*;
#(
   parameter int NUM_TIMERS = 4,
   parameter int WIDTH      = 32,
   parameter int PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  read_n,
   input  logic                  write_n,
   input  logic [31:0]           address,
   input  logic [31:0]           writeData,
   output logic [31:0]           readData,
   output logic [NUM_TIMERS-1:0] irq,
   output logic                  irq_any
`ifdef TIMER_PWM_EN
   ,output logic [NUM_TIMERS-1:0] pwm_out
`endif
);

   logic [3:0]            reg_idx_s;
   logic [3:0]            ch_idx_s;
   logic [31:0]           ch_rdata_s [NUM_TIMERS];
   logic [NUM_TIMERS-1:0] ch_irq_d_s;
   logic [31:0]           rd_mux_s;
   logic [31:0]           read_data_q, read_data_d;
   logic                  irq_any_q, irq_any_d;
   logic                  unused_addr_s;

   assign reg_idx_s     = address[5:2];
   assign ch_idx_s      = address[9:6];
   assign unused_addr_s = ^{address[31:10], address[1:0]};

   for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_ch
      logic wr_s;
      assign wr_s = !write_n && (ch_idx_s == 4'(g));
      timer_channel #(
         .WIDTH      (WIDTH),
         .PRESCALE_W (PRESCALE_W)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .wr_en_i   (wr_s),
         .reg_idx_i (reg_idx_s),
         .wdata_i   (writeData),
         .rdata_o   (ch_rdata_s[g]),
         .irq_o     (irq[g]),
         .irq_d_o   (ch_irq_d_s[g])
`ifdef TIMER_PWM_EN
         ,.pwm_o    (pwm_out[g])
`endif
      );
   end

   // Read mux: channels outside the bank contribute nothing
   always_comb begin
      rd_mux_s = 32'd0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
         rd_mux_s = rd_mux_s | ((ch_idx_s == 4'(i)) ? ch_rdata_s[i] : 32'd0);
      end
      read_data_d = !read_n ? rd_mux_s : 32'd0;
      irq_any_d   = |ch_irq_d_s;
   end

   // Read data and aggregate interrupt registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_data_q <= 32'd0;
         irq_any_q   <= 1'b0;
      end else begin
         read_data_q <= read_data_d;
         irq_any_q   <= irq_any_d;
      end
   end

   assign readData = read_data_q;
   assign irq_any  = irq_any_q;

endmodule

// File: tb/tb_avalon_timer_bank.sv
// Directed self-checking bench for avalon_timer_bank (default and TIMER_PWM_EN builds).
module tb_avalon_timer_bank;

   localparam int NT = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          read_n = 1'b1;
   logic          write_n = 1'b1;
   logic [31:0]   address = 32'd0;
   logic [31:0]   writeData = 32'd0;
   logic [31:0]   readData;
   logic [NT-1:0] irq;
   logic          irq_any;
`ifdef TIMER_PWM_EN
   logic [NT-1:0] pwm_out;
`endif

   int compared = 0;
   int mismatched = 0;

   avalon_timer_bank #(.NUM_TIMERS(NT), .WIDTH(32), .PRESCALE_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .read_n    (read_n),
      .write_n   (write_n),
      .address   (address),
      .writeData (writeData),
      .readData  (readData),
      .irq       (irq),
      .irq_any   (irq_any)
`ifdef TIMER_PWM_EN
      ,.pwm_out  (pwm_out)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] addr_of(input int ch, input int idx);
      logic [3:0] c;
      logic [3:0] r;
      c = 4'(ch);
      r = 4'(idx);
      return {22'd0, c, r, 2'b00};
   endfunction

   task automatic bus_write(input int ch, input int idx, input logic [31:0] data);
      @(negedge clk);
      address   = addr_of(ch, idx);
      writeData = data;
      write_n   = 1'b0;
      @(negedge clk);
      write_n   = 1'b1;
   endtask

   task automatic bus_read(input int ch, input int idx, output logic [31:0] data);
      @(negedge clk);
      address = addr_of(ch, idx);
      read_n  = 1'b0;
      @(negedge clk);
      read_n  = 1'b1;
      data    = readData;
   endtask

   initial begin
      logic [31:0] rd;
      int          highs;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      check("reset_irq", 32'(irq), 32'd0);
      check("reset_irq_any", 32'(irq_any), 32'd0);
      check("reset_readData", readData, 32'd0);
      for (int c = 0; c < NT; c++) begin
         bus_read(c, 0, rd); check($sformatf("reset_ctrl_ch%0d", c), rd, 32'd0);
         bus_read(c, 3, rd); check($sformatf("reset_count_ch%0d", c), rd, 32'd0);
         bus_read(c, 5, rd); check($sformatf("reset_status_ch%0d", c), rd, 32'd0);
      end

      // Ch0 periodic, RELOAD=4, PRESCALE=0: expiry at E+5, then every 5 clocks
      bus_write(0, 1, 32'd0);
      bus_write(0, 2, 32'd4);
      bus_write(0, 0, 32'h7);
      repeat (4) @(negedge clk);
      check("ch0_irq_before_expiry", 32'(irq[0]), 32'd0);
      @(negedge clk);
      check("ch0_irq_at_E+5", 32'(irq[0]), 32'd1);
      check("ch0_irq_any_at_E+5", 32'(irq_any), 32'd1);
      bus_write(0, 5, 32'd1);
      check("ch0_irq_after_w1c", 32'(irq[0]), 32'd0);
      check("ch0_irq_any_after_w1c", 32'(irq_any), 32'd0);
      repeat (2) @(negedge clk);
      check("ch0_irq_before_2nd", 32'(irq[0]), 32'd0);
      @(negedge clk);
      check("ch0_irq_at_E+10", 32'(irq[0]), 32'd1);

      // W1C landing on the E+15 expiry: the set must win
      repeat (3) @(negedge clk);
      bus_write(0, 5, 32'd1);
      check("ch0_set_wins_irq", 32'(irq[0]), 32'd1);
      bus_read(0, 5, rd);
      check("ch0_set_wins_status", rd, 32'd1);

      bus_write(0, 0, 32'd0);
      bus_write(0, 5, 32'd1);
      check("ch0_disabled_irq", 32'(irq[0]), 32'd0);
      check("ch0_disabled_irq_any", 32'(irq_any), 32'd0);
      bus_read(0, 0, rd);
      check("ch0_ctrl_disabled", rd, 32'd0);

      // Ch2 one-shot, RELOAD=3, PRESCALE=2: expiry 12 clocks after enable
      bus_write(2, 2, 32'd3);
      bus_write(2, 1, 32'd2);
      bus_write(2, 0, 32'h5);
      repeat (11) @(negedge clk);
      check("ch2_irq_at_E+11", 32'(irq[2]), 32'd0);
      @(negedge clk);
      check("ch2_irq_at_E+12", 32'(irq[2]), 32'd1);
      bus_read(2, 0, rd);
      check("ch2_ctrl_en_cleared", rd, 32'h4);
      bus_read(2, 3, rd);
      check("ch2_count_zero", rd, 32'd0);
      repeat (5) @(negedge clk);
      bus_read(2, 3, rd);
      check("ch2_count_stays_zero", rd, 32'd0);
      bus_read(2, 5, rd);
      check("ch2_status_expired", rd, 32'd1);
      @(negedge clk);
      check("readData_idle_zero", readData, 32'd0);
      bus_read(2, 1, rd);
      check("ch2_prescale_readback", rd, 32'd2);
      bus_write(2, 5, 32'd1);

      // Out-of-range channel and unused register index
      bus_write(NT, 3, 32'hDEAD);
      bus_read(NT, 3, rd);
      check("bad_channel_read", rd, 32'd0);
      bus_write(1, 9, 32'h1234);
      bus_read(1, 9, rd);
      check("bad_index_read", rd, 32'd0);

      // Truncation of PRESCALE to 8 bits
      bus_write(1, 1, 32'hABCD);
      bus_read(1, 1, rd);
      check("prescale_truncated", rd, 32'hCD);

      // Simultaneous read and write of COUNT returns the old value
      @(negedge clk);
      address   = addr_of(1, 3);
      writeData = 32'h55;
      read_n    = 1'b0;
      write_n   = 1'b0;
      @(negedge clk);
      read_n    = 1'b1;
      write_n   = 1'b1;
      check("rw_same_cycle_old", readData, 32'd0);
      bus_read(1, 3, rd);
      check("rw_same_cycle_new", rd, 32'h55);

      // COMPARE register
      bus_write(1, 4, 32'h12);
      bus_read(1, 4, rd);
`ifdef TIMER_PWM_EN
      check("compare_readback", rd, 32'h12);

      // PWM: RELOAD=9, COMPARE=3 -> 3 high clocks per 10
      bus_write(3, 2, 32'd9);
      bus_write(3, 4, 32'd3);
      bus_write(3, 0, 32'h3);
      highs = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         highs += int'(pwm_out[3]);
      end
      check("pwm_high_count", 32'(highs), 32'd6);
      bus_write(3, 0, 32'h0);
`else
      check("compare_absent", rd, 32'd0);
      highs = 0;
`endif

      // Asynchronous reset mid-count clears everything; nothing restarts by itself
      bus_write(0, 2, 32'd4);
      bus_write(0, 0, 32'h7);
      repeat (7) @(negedge clk);
      check("pre_reset_irq", 32'(irq[0]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_irq", 32'(irq), 32'd0);
      check("async_reset_irq_any", 32'(irq_any), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("post_reset_irq", 32'(irq), 32'd0);
      bus_read(0, 3, rd);
      check("post_reset_count", rd, 32'd0);
      bus_read(0, 0, rd);
      check("post_reset_ctrl", rd, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
